// File: rtl/bcd_time_counter.sv
// Real-time clock core: 1 s prescaler plus packed-BCD hh:mm:ss with a freeze-and-adjust set mode.
// Optional 12 h mode with PM flag is enabled by defining BCD_TIME_COUNTER_HOUR12_EN.
module bcd_time_counter #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       inc,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       pm,
  output logic       tick
);

  localparam logic [CNT_W-1:0] TickMax = CNT_W'(TICK_DIV - 1);

`ifdef BCD_TIME_COUNTER_HOUR12_EN
  localparam logic [7:0] HourReset = 8'h12;

  function automatic logic [7:0] hour_next(input logic [7:0] v);
    if (v == 8'h12)            return 8'h01;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction
`else
  localparam logic [7:0] HourReset = 8'h00;

  function automatic logic [7:0] hour_next(input logic [7:0] v);
    if (v == 8'h23)            return 8'h00;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction
`endif

  function automatic logic [7:0] sixty_next(input logic [7:0] v);
    if (v == 8'h59)            return 8'h00;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic             tick_q, tick_d;
  logic             inc_q;
  logic             hour_step;

  always_comb begin
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    hour_step = 1'b0;
    if (set_en) begin
      cnt_d = '0;
      if (inc && !inc_q) begin
        case (set_sel)
          2'b00:   sec_d     = 8'h00;
          2'b01:   min_d     = sixty_next(min_q);
          2'b10:   hour_step = 1'b1;
          default: ;
        endcase
      end
    end else if (cnt_q == TickMax) begin
      // Whole carry chain settles on the tick edge.
      cnt_d  = '0;
      tick_d = 1'b1;
      sec_d  = sixty_next(sec_q);
      if (sec_q == 8'h59) begin
        min_d = sixty_next(min_q);
        if (min_q == 8'h59) hour_step = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (hour_step) hour_d = hour_next(hour_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      inc_q  <= 1'b0;
      hour_q <= HourReset;
      min_q  <= 8'h00;
      sec_q  <= 8'h00;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      inc_q  <= inc;
      hour_q <= hour_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
    end
  end

`ifdef BCD_TIME_COUNTER_HOUR12_EN
  logic pm_q, pm_d;

  // Entering 12 from 11 flips the half-day, by carry or by set-mode press.
  always_comb pm_d = pm_q ^ (hour_step && (hour_q == 8'h11));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pm_q <= 1'b0;
    else         pm_q <= pm_d;
  end

  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

  assign hour   = hour_q;
  assign minute = min_q;
  assign second = sec_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter: vector table, integer reference model and scoreboard.
module tb_bcd_time_counter;

  localparam int unsigned TickDiv = 4;

`ifdef BCD_TIME_COUNTER_HOUR12_EN
  localparam logic [7:0] Hr0 = 8'h12;
  localparam int HSet = 11;
  localparam logic [24:0] WrapExp = {8'h12, 8'h00, 8'h00, 1'b1};
  localparam logic [24:0] OneExp  = {8'h01, 8'h00, 8'h00, 1'b1};
`else
  localparam logic [7:0] Hr0 = 8'h00;
  localparam int HSet = 23;
  localparam logic [24:0] WrapExp = {8'h00, 8'h00, 8'h00, 1'b0};
  localparam logic [24:0] OneExp  = {8'h01, 8'h00, 8'h00, 1'b0};
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'b00;
  logic       inc = 1'b0;
  logic [7:0] hour, minute, second;
  logic       pm, tick;
  logic [25:0] dut_vec;

  int checks = 0;
  int failures = 0;

  logic [25:0] exp_q[$];

  // Reference model state (plain integers)
  int mh, mm, ms, mcnt;
  bit mpm, mprev, mtick;

  typedef struct {
    logic        se;
    logic [1:0]  sel;
    logic        in_v;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs[23];

  bcd_time_counter #(
    .TICK_DIV(TickDiv),
    .CNT_W   (3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .set_en (set_en),
    .set_sel(set_sel),
    .inc    (inc),
    .hour   (hour),
    .minute (minute),
    .second (second),
    .pm     (pm),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  assign dut_vec = {hour, minute, second, pm, tick};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] pk(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s, input logic t);
    return {h, m, s, 1'b0, t};
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [25:0] model_exp();
    return {bcd(mh), bcd(mm), bcd(ms), mpm, mtick};
  endfunction

  task automatic model_reset();
    mh = int'(Hr0 == 8'h12 ? 12 : 0);
    mm = 0; ms = 0; mcnt = 0;
    mpm = 1'b0; mprev = 1'b0; mtick = 1'b0;
  endtask

  task automatic model_hour_inc();
`ifdef BCD_TIME_COUNTER_HOUR12_EN
    mh = (mh == 12) ? 1 : mh + 1;
    if (mh == 12) mpm = !mpm;
`else
    mh = (mh + 1) % 24;
`endif
  endtask

  task automatic model_step(input logic se, input logic [1:0] sel, input logic in_v);
    mtick = 1'b0;
    if (se) begin
      mcnt = 0;
      if (in_v && !mprev) begin
        if (sel == 2'd0) ms = 0;
        else if (sel == 2'd1) mm = (mm + 1) % 60;
        else if (sel == 2'd2) model_hour_inc();
      end
    end else if (mcnt == int'(TickDiv) - 1) begin
      mcnt = 0;
      mtick = 1'b1;
      ms++;
      if (ms == 60) begin
        ms = 0;
        mm++;
        if (mm == 60) begin
          mm = 0;
          model_hour_inc();
        end
      end
    end else begin
      mcnt++;
    end
    mprev = in_v;
  endtask

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; expected value comes from the table when use_tab, else from the model.
  task automatic cyc(input logic se, input logic [1:0] sel, input logic in_v, input string name,
                     input logic use_tab, input logic [25:0] tab);
    set_en = se; set_sel = sel; inc = in_v;
    model_step(se, sel, in_v);
    exp_q.push_back(use_tab ? tab : model_exp());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, dut_vec, exp_q.pop_front());
    end
  endtask

  task automatic run(input logic se, input logic [1:0] sel, input logic in_v, input string name);
    cyc(se, sel, in_v, name, 1'b0, '0);
  endtask

  task automatic press(input logic [1:0] sel, input string name);
    run(1'b1, sel, 1'b1, name);
    run(1'b1, sel, 1'b0, name);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 1'b0, pk(Hr0, 8'h00, 8'h00, 1'b0)};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, pk(Hr0, 8'h00, 8'h00, 1'b0)};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, pk(Hr0, 8'h00, 8'h00, 1'b0)};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, pk(Hr0, 8'h00, 8'h01, 1'b1)};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, pk(Hr0, 8'h00, 8'h01, 1'b0)};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, pk(Hr0, 8'h00, 8'h01, 1'b0)};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, pk(Hr0, 8'h00, 8'h01, 1'b0)};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, pk(Hr0, 8'h00, 8'h02, 1'b1)};
    vecs[8]  = '{1'b1, 2'd1, 1'b1, pk(Hr0, 8'h01, 8'h02, 1'b0)};
    vecs[9]  = '{1'b1, 2'd1, 1'b1, pk(Hr0, 8'h01, 8'h02, 1'b0)};
    vecs[10] = '{1'b1, 2'd1, 1'b0, pk(Hr0, 8'h01, 8'h02, 1'b0)};
    vecs[11] = '{1'b1, 2'd2, 1'b1, pk(8'h01, 8'h01, 8'h02, 1'b0)};
    vecs[12] = '{1'b1, 2'd0, 1'b0, pk(8'h01, 8'h01, 8'h02, 1'b0)};
    vecs[13] = '{1'b1, 2'd0, 1'b1, pk(8'h01, 8'h01, 8'h00, 1'b0)};
    vecs[14] = '{1'b1, 2'd3, 1'b0, pk(8'h01, 8'h01, 8'h00, 1'b0)};
    vecs[15] = '{1'b1, 2'd3, 1'b1, pk(8'h01, 8'h01, 8'h00, 1'b0)};
    vecs[16] = '{1'b0, 2'd1, 1'b1, pk(8'h01, 8'h01, 8'h00, 1'b0)};
    vecs[17] = '{1'b0, 2'd1, 1'b0, pk(8'h01, 8'h01, 8'h00, 1'b0)};
    vecs[18] = '{1'b0, 2'd1, 1'b1, pk(8'h01, 8'h01, 8'h00, 1'b0)};
    vecs[19] = '{1'b0, 2'd1, 1'b0, pk(8'h01, 8'h01, 8'h01, 1'b1)};
    vecs[20] = '{1'b0, 2'd1, 1'b1, pk(8'h01, 8'h01, 8'h01, 1'b0)};
    vecs[21] = '{1'b1, 2'd1, 1'b1, pk(8'h01, 8'h01, 8'h01, 1'b0)};
    vecs[22] = '{1'b1, 2'd1, 1'b0, pk(8'h01, 8'h01, 8'h01, 1'b0)};

    // Async reset, checked before any clock edge
    #1 resetn = 1'b0;
    #1 check("reset_async", dut_vec, pk(Hr0, 8'h00, 8'h00, 1'b0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_reset();

    for (int i = 0; i < 23; i++)
      cyc(vecs[i].se, vecs[i].sel, vecs[i].in_v, $sformatf("vec%0d", i), 1'b1, vecs[i].exp);

    // Free run across 09 -> 10
    for (int k = 0; k < 60; k++) run(1'b0, 2'd0, 1'b0, "run_seconds");

    // Preload HH:59:00, run to :58, then two ticks wrap the whole chain
    for (int k = 0; k < 30 && mh != HSet; k++) press(2'd2, "set_hour");
    for (int k = 0; k < 70 && mm != 59; k++) press(2'd1, "set_min");
    press(2'd0, "clr_sec");
    for (int k = 0; k < 400 && ms != 58; k++) run(1'b0, 2'd0, 1'b0, "run_to_58");
    for (int k = 0; k < 20 && ms != 0; k++) run(1'b0, 2'd0, 1'b0, "run_wrap");
    check("day_wrap", dut_vec[25:1], WrapExp);
    check("day_wrap_tick", {25'd0, tick}, 26'd1);

    // xx:59:59 -> 01:00:00
    for (int k = 0; k < 70 && mm != 59; k++) press(2'd1, "set_min2");
    press(2'd0, "clr_sec2");
    for (int k = 0; k < 400 && ms != 59; k++) run(1'b0, 2'd0, 1'b0, "run_to_59");
    for (int k = 0; k < 20 && ms != 0; k++) run(1'b0, 2'd0, 1'b0, "run_hour");
    check("hour_advance", dut_vec[25:1], OneExp);

    // Set-mode minute wrap without hour carry, then held inc
    for (int k = 0; k < 70 && mm != 59; k++) press(2'd1, "set_min3");
    press(2'd1, "min_wrap");
    check("min_wrap_no_carry", {10'd0, hour, minute}, {10'd0, 8'h01, 8'h00});
    for (int k = 0; k < 10; k++) run(1'b1, 2'd1, 1'b1, "inc_held");
    run(1'b1, 2'd1, 1'b0, "inc_release");
    check("inc_held_once", {18'd0, minute}, {18'd0, 8'h01});

    // Frozen for 20 cycles, then first tick TICK_DIV edges after release
    for (int k = 0; k < 20; k++) run(1'b1, 2'd3, 1'b0, "frozen");
    for (int k = 0; k < int'(TickDiv); k++) run(1'b0, 2'd0, 1'b0, "release");
    check("first_tick_after_set", {17'd0, second, tick}, {17'd0, 8'h01, 1'b1});

    // Mixed random stimulus against the model
    for (int k = 0; k < 300; k++)
      run(logic'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
          logic'($urandom_range(0, 1)), "random");

    // Reset mid-count, visible without a clock edge
    #3 resetn = 1'b0;
    #1 check("reset_midcount", dut_vec, pk(Hr0, 8'h00, 8'h00, 1'b0));
    @(posedge clk);
    #1 check("reset_held", dut_vec, pk(Hr0, 8'h00, 8'h00, 1'b0));
    resetn = 1'b1;
    model_reset();
    for (int k = 0; k < 2 * int'(TickDiv); k++) run(1'b0, 2'd0, 1'b0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
